// File: rtl/key_debounce8.sv
// Eight-channel key synchroniser and debouncer feeding the 8-to-3 priority encoder.
// Each key is accepted only after its new level is seen on STABLE_TICKS consecutive prescaler ticks.
module key_debounce8 #(
  parameter int N            = 8,
  parameter int TICK_DIV     = 1000,
  parameter int STABLE_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] key_raw,
  output logic [N-1:0] key_out,
  output logic [N-1:0] key_press,
  output logic         key_any
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_W = $clog2(STABLE_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [N-1:0]     s1_q, s2_q;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             tick;
  logic [N-1:0]     key_out_q, key_out_d;
  logic [N-1:0]     key_press_q, key_press_d;
  logic             key_any_q, key_any_d;

  always_comb begin
    tick      = (div_cnt_q == DIV_LAST);
    div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_key
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             differ;
      logic             flip;

      assign differ = s2_q[gi] ^ key_out_q[gi];

      // Any tick that sees the accepted level again discards the run so far.
      always_comb begin
        cnt_d = cnt_q;
        flip  = 1'b0;
        if (tick) begin
          if (!differ) begin
            cnt_d = '0;
          end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            flip  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      assign key_out_d[gi] = key_out_q[gi] ^ flip;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  always_comb begin
    key_press_d = key_out_d & ~key_out_q;
    key_any_d   = |key_out_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q        <= '0;
      s2_q        <= '0;
      div_cnt_q   <= '0;
      key_out_q   <= '0;
      key_press_q <= '0;
      key_any_q   <= 1'b0;
    end else begin
      s1_q        <= key_raw;
      s2_q        <= s1_q;
      div_cnt_q   <= div_cnt_d;
      key_out_q   <= key_out_d;
      key_press_q <= key_press_d;
      key_any_q   <= key_any_d;
    end
  end

  assign key_out   = key_out_q;
  assign key_press = key_press_q;
  assign key_any   = key_any_q;

endmodule

// File: tb/tb_key_debounce8.sv
// Self-checking bench for key_debounce8: per-cycle comparison against a tick-counting
// behavioural model, plus directed scenarios with hand-computed timing.
module tb_key_debounce8;
  localparam int N  = 8;
  localparam int TD = 4;
  localparam int ST = 3;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] key_raw = '0;
  logic [N-1:0] key_out;
  logic [N-1:0] key_press;
  logic         key_any;

  int checks = 0;
  int errors = 0;

  key_debounce8 #(.N(N), .TICK_DIV(TD), .STABLE_TICKS(ST)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_raw   (key_raw),
    .key_out   (key_out),
    .key_press (key_press),
    .key_any   (key_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: raw history gives the synchronised level, cycle count since reset gives ticks,
  // and a per-key run length of differing ticks decides acceptance.
  logic [N-1:0] m_hist1 = '0, m_hist2 = '0;
  logic [N-1:0] m_out = '0, m_press = '0, m_nxt;
  logic         m_any = 1'b0;
  int           m_cyc = 0;
  int           m_run [N];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_hist1 = '0; m_hist2 = '0; m_out = '0; m_press = '0; m_any = 1'b0; m_cyc = 0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
    end else begin
      m_nxt = m_out;
      if ((m_cyc % TD) == TD - 1) begin
        for (int i = 0; i < N; i++) begin
          if (m_hist2[i] != m_out[i]) begin
            m_run[i] = m_run[i] + 1;
            if (m_run[i] == ST) begin
              m_nxt[i] = m_hist2[i];
              m_run[i] = 0;
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end
      m_press = m_nxt & ~m_out;
      m_out   = m_nxt;
      m_any   = (m_out != '0);
      m_cyc   = m_cyc + 1;
      m_hist2 = m_hist1;
      m_hist1 = key_raw;
    end
  end

  always @(negedge clk) begin
    check("model_key_out", 32'(key_out), 32'(m_out));
    check("model_key_press", 32'(key_press), 32'(m_press));
    check("model_key_any", 32'(key_any), 32'(m_any));
  end

  initial begin
    int w;
    // Reset with all keys pressed
    rst_n = 1'b0;
    key_raw = 8'hFF;
    repeat (5) begin
      @(negedge clk);
      check("rst_key_out", 32'(key_out), 32'h0);
      check("rst_key_press", 32'(key_press), 32'h0);
      check("rst_key_any", 32'(key_any), 32'h0);
    end

    // Clean press of key 2: accepted on the edge ending cycle 12
    rst_n = 1'b1;
    key_raw = 8'h04;
    repeat (11) @(negedge clk);
    check("clean_not_early", 32'(key_out), 32'h0);
    @(negedge clk);
    check("clean_key_out", 32'(key_out), 32'h04);
    check("clean_key_press", 32'(key_press), 32'h04);
    check("clean_key_any", 32'(key_any), 32'h1);
    @(negedge clk);
    check("clean_press_once", 32'(key_press), 32'h0);
    check("clean_hold", 32'(key_out), 32'h04);

    // Bounce on key 0: high 5 clk / low 5 clk never spans 3 ticks
    for (int k = 0; k < 6; k++) begin
      key_raw = 8'h05;
      repeat (5) @(negedge clk);
      key_raw = 8'h04;
      repeat (5) @(negedge clk);
    end
    check("bounce_key_out", 32'(key_out), 32'h04);

    // Release everything, then press keys 7 and 0 together
    key_raw = 8'h00;
    repeat (20) @(negedge clk);
    check("release_all", 32'(key_out), 32'h0);
    key_raw = 8'h81;
    w = 0;
    while (w < 20 && key_out !== 8'h81) begin
      @(negedge clk);
      w++;
    end
    check("simul_within_bound", 32'(w < 20), 32'h1);
    check("simul_key_out", 32'(key_out), 32'h81);
    check("simul_key_press", 32'(key_press), 32'h81);
    @(negedge clk);
    check("simul_press_once", 32'(key_press), 32'h0);
    key_raw = 8'h00;
    w = 0;
    while (w < 20 && key_out !== 8'h00) begin
      @(negedge clk);
      check("release_no_press", 32'(key_press), 32'h0);
      w++;
    end
    check("release_within_bound", 32'(w < 20), 32'h1);
    check("release_key_any", 32'(key_any), 32'h0);

    // Reset in the middle of key 5's count discards the two ticks already seen
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    key_raw = 8'h20;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (11) begin
      @(negedge clk);
      check("midrst_hold", 32'(key_out), 32'h0);
    end
    @(negedge clk);
    check("midrst_key_out", 32'(key_out), 32'h20);
    check("midrst_key_press", 32'(key_press), 32'h20);

    // Sweep all patterns, each held 20 ticks so it is fully settled
    for (int p = 0; p < 256; p++) begin
      key_raw = 8'(p);
      repeat (20 * TD) @(negedge clk);
      check("sweep_key_out", 32'(key_out), 32'(p));
      check("sweep_key_any", 32'(key_any), 32'(p != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
